// File: rtl/avr_spi_buf.sv
// avr_spi_buf: TX/RX byte FIFOs in front of the AVR SPI core's data register.
// The CPU pushes TX bytes and pops RX bytes through BUFD and controls and
// observes the buffer through BUFS. A small FSM hands TX bytes to the core one
// at a time and captures each received byte when the core finishes a transfer.
module avr_spi_buf #(
  parameter int         DEPTH_LOG2   = 2,
  parameter logic [5:0] BUFD_Address = 6'h30,
  parameter logic [5:0] BUFS_Address = 6'h31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic [5:0] adr,
  input  logic [7:0] dbus_in,
  input  logic       iore,
  input  logic       iowe,
  output logic [7:0] dbus_out,
  output logic       out_en,
  output logic       core_wr,
  output logic [7:0] core_wdata,
  input  logic       core_done,
  input  logic [7:0] core_rdata,
  output logic       bufirq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t state;

  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;

  logic en, ie, txovf, rxovf;
  logic wr_q;

  logic bufd_hit, bufs_hit;
  logic txempty, txfull, rxempty, rxfull;
  logic flush;
  logic tx_push_req, tx_push, tx_pop, tx_drop;
  logic rx_take, rx_push, rx_pop, rx_drop;
  logic [7:0] status;

  assign bufd_hit = (adr == BUFD_Address);
  assign bufs_hit = (adr == BUFS_Address);

  assign txempty = (tx_cnt == '0);
  assign txfull  = (tx_cnt == FULL_CNT);
  assign rxempty = (rx_cnt == '0);
  assign rxfull  = (rx_cnt == FULL_CNT);

  // Clearing en flushes both FIFOs; it overrides every other pointer update.
  assign flush = clken & iowe & bufs_hit & en & ~dbus_in[7];

  // A full TX still accepts a push when the FSM frees a slot on the same edge.
  assign tx_pop      = clken & (state == LOAD) & ~txempty;
  assign tx_push_req = clken & iowe & bufd_hit;
  assign tx_push     = tx_push_req & (~txfull | tx_pop);
  assign tx_drop     = tx_push_req & txfull & ~tx_pop;

  // Received bytes are discarded once the buffer has been disabled.
  assign rx_pop  = clken & iore & bufd_hit & ~rxempty;
  assign rx_take = clken & (state == WAIT) & core_done & en & ~flush;
  assign rx_push = rx_take & (~rxfull | rx_pop);
  assign rx_drop = rx_take & rxfull & ~rx_pop;

  assign status = {en, ie, rxovf, txovf, rxfull, rxempty, txfull, txempty};

  assign out_en  = iore & (bufd_hit | bufs_hit);
  assign core_wr = wr_q & clken;

  // Combinational read mux for the two I/O registers.
  always_comb begin
    dbus_out = 8'h00;
    if (bufd_hit) begin
      dbus_out = rxempty ? 8'h00 : rx_mem[rx_rd];
    end else if (bufs_hit) begin
      dbus_out = status;
    end
  end

  // FIFO storage; contents need no reset because counts gate every read.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= dbus_in;
    if (rx_push) rx_mem[rx_wr] <= core_rdata;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      tx_cnt <= tx_cnt + (DEPTH_LOG2 + 1)'(tx_push) - (DEPTH_LOG2 + 1)'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      rx_cnt <= rx_cnt + (DEPTH_LOG2 + 1)'(rx_push) - (DEPTH_LOG2 + 1)'(rx_pop);
    end
  end

  // Control bits and sticky overflow flags; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en    <= 1'b0;
      ie    <= 1'b0;
      txovf <= 1'b0;
      rxovf <= 1'b0;
    end else if (clken) begin
      if (iowe && bufs_hit) begin
        en <= dbus_in[7];
        ie <= dbus_in[6];
        if (dbus_in[4]) txovf <= 1'b0;
        if (dbus_in[5]) rxovf <= 1'b0;
      end
      if (tx_drop) txovf <= 1'b1;
      if (rx_drop) rxovf <= 1'b1;
    end
  end

  // Transfer FSM with registered core strobe, core data and interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      core_wdata <= 8'h00;
      bufirq     <= 1'b0;
    end else if (clken) begin
      bufirq <= ie & en & txempty & (state == IDLE);
      case (state)
        IDLE: begin
          // A flush on this edge cancels the launch so no stale byte escapes.
          if (en && !txempty && !flush) begin
            state      <= LOAD;
            wr_q       <= 1'b1;
            core_wdata <= tx_mem[tx_rd];
          end
        end
        LOAD: begin
          state <= WAIT;
          wr_q  <= 1'b0;
        end
        WAIT: begin
          if (core_done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/avr_spi_buf.md
Name: avr_spi_buf

Overview:
- Byte-buffering front end for the AVR SPI core; sits directly upstream of the SPI data register.
- Software fills a TX FIFO and drains an RX FIFO through two I/O registers.
- The block feeds TX bytes one at a time into the core's SPDR write path and captures each received byte when the core signals transfer complete.
- Lets the CPU queue multi-byte SPI bursts without servicing every byte.

Parameters:
- DEPTH_LOG2, 2, log2 of depth for each FIFO (TX and RX each hold 2**DEPTH_LOG2 bytes).
- BUFD_Address, 6'h30, I/O address of the buffer data register (write = TX push, read = RX pop).
- BUFS_Address, 6'h31, I/O address of the buffer status/control register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- clken  input  1  clock enable; all non-reset state updates are qualified by clken=1.
- adr  input  6  I/O address.
- dbus_in  input  8  I/O write data.
- iore  input  1  I/O read strobe.
- iowe  input  1  I/O write strobe.
- dbus_out  output  8  I/O read data.
- out_en  output  1  high when a read hits BUFD_Address or BUFS_Address.
- core_wr  output  1  one-cycle strobe that writes core_wdata into the core's SPDR and starts a transfer.
- core_wdata  output  8  byte for the core.
- core_done  input  1  one-cycle pulse from the core when a transfer completes (SPIF set).
- core_rdata  input  8  received byte from the core, valid while core_done=1.
- bufirq  output  1  buffer-drained interrupt, level.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - Both FIFOs empty; pointers and counts = 0.
  - en=0, ie=0, txovf=0, rxovf=0; state=IDLE.
  - core_wr=0, core_wdata=8'h00, bufirq=0.
- BUFS layout: [0] txempty (RO), [1] txfull (RO), [2] rxempty (RO), [3] rxfull (RO), [4] txovf (W1C), [5] rxovf (W1C), [6] ie (RW), [7] en (RW).
- Reads are combinational:
  - out_en = iore & (adr==BUFD_Address | adr==BUFS_Address).
  - dbus_out = RX head for BUFD (8'h00 if RX empty), the status byte for BUFS, else 8'h00.
- RX pop: an iore hit on BUFD with RX non-empty pops one entry on that clken edge. A read while RX is empty does not pop and does not change the pointer.
- TX push: an iowe hit on BUFD pushes dbus_in. If TX is full, the byte is dropped and txovf is set (sticky).
- BUFS write behaviour:
  - Sets ie and en from the written data.
  - A 1 in bit 4 or bit 5 clears txovf or rxovf respectively.
  - An en 1->0 write flushes both FIFOs on the same edge.
- FSM states: IDLE, LOAD, WAIT.
  - IDLE -> LOAD when en & !txempty.
  - LOAD, one cycle: core_wr=1, core_wdata = TX head; the TX head is popped on this edge; -> WAIT.
  - WAIT -> IDLE on core_done. On that edge core_rdata is pushed to RX.
  - If RX is full at that point, the byte is dropped and rxovf is set.
  - If en=0 (cleared mid-transfer), the byte is discarded and no flag is set.
- Throughput: a back-to-back transfer is issued at the earliest 2 clken cycles after core_done (IDLE -> LOAD -> core_wr).
- core_wr is registered; it is high only in LOAD and low whenever clken=0.
- Simultaneous events:
  - TX push and FSM pop on the same edge: both take effect, and the count is unchanged.
  - RX push (core_done) and CPU pop on the same edge: both take effect. If RX was full, the pop frees space first, so no overrun.
  - A push to a full TX on the same edge as an FSM pop is accepted, with no txovf.
- core_done outside WAIT is ignored.
- Pointers wrap modulo 2**DEPTH_LOG2. Full and empty are distinguished by a DEPTH_LOG2+1-bit count.
- bufirq = ie & en & txempty & (state==IDLE), registered.
- Reset mid-transfer returns to IDLE with no core_wr. The core is responsible for its own abort.

Test Plan:
- Reset, then read BUFS -> 8'h05 (txempty, rxempty). Read BUFD -> 8'h00, out_en=1.
- en=1, push 8'hA5 -> core_wr pulses once with core_wdata=8'hA5. Drive core_done with core_rdata=8'h3C -> BUFD read returns 8'h3C, then BUFS bit2=1.
- en=0, push 5 bytes with DEPTH_LOG2=2 -> txfull=1, txovf=1, 4 bytes retained. Write BUFS 8'h10 -> txovf clears.
- en=1, queue 4 bytes, never read RX, complete 5 transfers (one extra byte pushed during the transfers) -> rxfull=1, rxovf=1, RX holds the first 4 received bytes in order.
- ie=1, en=1, queue 2 bytes, complete both -> bufirq rises one cycle after the FSM returns to IDLE with TX empty. Push a new byte -> bufirq falls.
- Clear en during WAIT with 2 bytes still queued -> FIFOs flushed, subsequent core_done ignored (RX stays empty, rxovf=0), no further core_wr.
